// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and constants for the UART transmit controller.
//   - state_e            : controller FSM states
//   - SEL_*              : downstream output-mux select codes
//   - DEFAULT_DATA_WIDTH : default payload width in bits
// Configuration macro: UART_TX_PARITY_EN (adds the PARITY state when defined).
package uart_tx_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_STOP  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc: registers the parity of a byte when load_i is high.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset (clears par_o)
//   data_i    : byte whose parity is computed
//   par_typ_i : 0 = even, 1 = odd
//   load_i    : capture strobe
//   par_o     : registered parity bit, held until the next load
module uart_tx_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    input  logic                  load_i,
    output logic                  par_o
);

    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (load_i) begin
            par_d = (^data_i) ^ par_typ_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_o = par_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit controller (FSM + LSB-first serializer).
//   CLK        : system/baud clock, one frame bit per cycle
//   RST        : asynchronous active-low reset
//   P_DATA     : parallel byte, latched when DATA_VALID is seen in IDLE
//   DATA_VALID : byte valid strobe, ignored while busy
//   PAR_EN     : parity enable, latched with the byte
//   PAR_TYP    : parity type, 0 = even, 1 = odd
//   ser_data   : current serial bit (shift register LSB)
//   par_bit    : parity of the latched byte
//   mux_sel    : output-mux select 00 start, 01 stop/idle, 10 data, 11 parity
//   busy       : high while a frame is in flight
// Configuration macro: UART_TX_PARITY_EN. Undefined: no PARITY state, PAR_EN/PAR_TYP
// ignored, par_bit tied low.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic [1:0]            mux_sel,
    output logic                  busy
);

    // Keep the counter at least one bit wide for DATA_WIDTH == 1.
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  load;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d = par_en_q;
`endif
        case (state_q)
            StIdle: begin
                if (DATA_VALID) begin
                    load    = 1'b1;
                    shift_d = P_DATA;
                    cnt_d   = '0;
                    state_d = StStart;
`ifdef UART_TX_PARITY_EN
                    par_en_d = PAR_EN;
`endif
                end
            end
            // No shift here: bit 0 must still be at the LSB in the first DATA cycle.
            StStart: state_d = StData;
            StData: begin
                shift_d = shift_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    state_d = par_en_q ? StParity : StStop;
`else
                    state_d = StStop;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: state_d = StStop;
`endif
            StStop:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q <= 1'b0;
        end else begin
            par_en_q <= par_en_d;
        end
    end

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .data_i    (P_DATA),
        .par_typ_i (PAR_TYP),
        .load_i    (load),
        .par_o     (par_bit)
    );
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP ^ load;
    assign par_bit    = 1'b0;
`endif

    // Moore outputs, decoded only from registered state.
    always_comb begin
        mux_sel = SEL_STOP;
        case (state_q)
            StStart: mux_sel = SEL_START;
            StData:  mux_sel = SEL_DATA;
`ifdef UART_TX_PARITY_EN
            StParity: mux_sel = SEL_PAR;
`endif
            default: mux_sel = SEL_STOP;
        endcase
    end

    assign ser_data = shift_q[0];
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed scoreboard bench for uart_tx_ctrl.
// Expected per-cycle frame contents are queued when a byte is offered and popped
// one per clock while the frame is on the wire.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_data;
    logic       par_bit;
    logic [1:0] mux_sel;
    logic       busy;

    typedef struct packed {
        logic [1:0] sel;
        logic       chk_ser;
        logic       ser;
        logic       par;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    uart_tx_ctrl #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .mux_sel    (mux_sel),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns just after the accepting edge.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        logic p;
        exp_t e;
        p = PAR_BUILT ? ((^d) ^ pt) : 1'b0;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        e = '{sel: 2'b00, chk_ser: 1'b0, ser: 1'b0, par: p};
        q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            e = '{sel: 2'b10, chk_ser: 1'b1, ser: d[i], par: p};
            q.push_back(e);
        end
        if (PAR_BUILT && pe) begin
            e = '{sel: 2'b11, chk_ser: 1'b0, ser: 1'b0, par: p};
            q.push_back(e);
        end
        e = '{sel: 2'b01, chk_ser: 1'b0, ser: 1'b0, par: p};
        q.push_back(e);
        @(posedge CLK);
        #1 DATA_VALID = 1'b0;
    endtask

    task automatic pop_check();
        exp_t e;
        @(negedge CLK);
        e = q.pop_front();
        check("mux_sel", {6'd0, mux_sel}, {6'd0, e.sel});
        check("busy", {7'd0, busy}, 8'd1);
        check("par_bit", {7'd0, par_bit}, {7'd0, e.par});
        if (e.chk_ser) begin
            check("ser_data", {7'd0, ser_data}, {7'd0, e.ser});
        end
    endtask

    // Drains the queued frame; optionally disturbs the inputs from cycle inj_at on.
    task automatic drain(input int inj_at, input logic [7:0] inj_d,
                         input logic inj_pe, input logic inj_pt);
        int n;
        n = q.size();
        for (int i = 0; i < n; i++) begin
            pop_check();
            if (i == inj_at) begin
                DATA_VALID = 1'b1;
                P_DATA     = inj_d;
                PAR_EN     = inj_pe;
                PAR_TYP    = inj_pt;
            end
            if (i == inj_at + 3) DATA_VALID = 1'b0;
        end
        @(negedge CLK);
        check("idle_busy", {7'd0, busy}, 8'd0);
        check("idle_sel", {6'd0, mux_sel}, 8'h01);
    endtask

    initial begin
        RST        = 1'b0;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b1;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #2;
        check("rst_sel", {6'd0, mux_sel}, 8'h01);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_ser", {7'd0, ser_data}, 8'd0);
        check("rst_par", {7'd0, par_bit}, 8'd0);

        // DATA_VALID held through an edge while in reset must not start a frame.
        @(negedge CLK);
        check("rst_hold_busy", {7'd0, busy}, 8'd0);
        DATA_VALID = 1'b0;
        RST        = 1'b1;
        @(negedge CLK);
        check("post_rst_busy", {7'd0, busy}, 8'd0);

        send(8'hA5, 1'b1, 1'b0);
        drain(-1, 8'h00, 1'b0, 1'b0);
        send(8'hA5, 1'b1, 1'b1);
        drain(-1, 8'h00, 1'b0, 1'b0);
        send(8'h3C, 1'b0, 1'b0);
        drain(-1, 8'h00, 1'b0, 1'b0);

        // Second strobe and parity-control changes mid-frame must be ignored.
        send(8'h01, 1'b0, 1'b0);
        drain(3, 8'hFF, 1'b1, 1'b1);
        send(8'h5E, 1'b1, 1'b1);
        drain(2, 8'h00, 1'b0, 1'b0);

        // Reset asserted in the 4th DATA cycle.
        send(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) pop_check();
        #1 RST = 1'b0;
        #1;
        check("midrst_sel", {6'd0, mux_sel}, 8'h01);
        check("midrst_busy", {7'd0, busy}, 8'd0);
        check("midrst_ser", {7'd0, ser_data}, 8'd0);
        check("midrst_par", {7'd0, par_bit}, 8'd0);
        q.delete();
        DATA_VALID = 1'b1;
        P_DATA     = 8'hFF;
        @(negedge CLK);
        check("midrst_hold", {7'd0, busy}, 8'd0);
        DATA_VALID = 1'b0;
        RST        = 1'b1;
        @(negedge CLK);
        check("midrst_rel", {7'd0, busy}, 8'd0);

        send(8'hA5, 1'b1, 1'b0);
        drain(-1, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
